// File: rtl/ysyx_041461_pipe_stage_reg_if.sv
// Handshake bundle between two pipeline stages: the upstream beat, the
// downstream beat, plus flush and the stage's held-entry count.
interface ysyx_041461_pipe_stage_reg_if #(
    parameter int DATA_W = 100
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_kill;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    modport master (
        output flush, in_valid, in_kill, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_kill, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/ysyx_041461_pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready handshake, optional 2-entry
// skid buffer (registered in_ready), synchronous flush and per-beat kill.
module ysyx_041461_pipe_stage_reg #(
    parameter int                DATA_W   = 100,
    parameter logic [DATA_W-1:0] RST_DATA = {4'h0, 32'h0, 64'h0000_0000_3000_0000},
    parameter bit                SKID     = 1'b1
) (
    input logic                        clk,
    input logic                        rst,
    ysyx_041461_pipe_stage_reg_if.slave bus
);

    generate
        if (SKID) begin : g_skid
            typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

            state_t            state_reg;
            logic [DATA_W-1:0] main_reg;
            logic [DATA_W-1:0] skid_reg;
            logic              out_valid_reg;
            logic              in_ready_reg;
            logic [1:0]        occupancy_reg;

            logic in_fire;
            logic accept;
            logic out_fire;

            assign in_fire  = bus.in_valid & in_ready_reg;
            assign accept   = in_fire & ~bus.in_kill & ~bus.flush;
            assign out_fire = out_valid_reg & bus.out_ready;

            // Handshake outputs are registered next to the state so in_ready
            // never depends combinationally on out_ready.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg     <= EMPTY;
                    main_reg      <= RST_DATA;
                    skid_reg      <= RST_DATA;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    occupancy_reg <= 2'd0;
                end else if (bus.flush) begin
                    state_reg     <= EMPTY;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    occupancy_reg <= 2'd0;
                end else begin
                    case (state_reg)
                        EMPTY: begin
                            if (accept) begin
                                main_reg      <= bus.in_data;
                                state_reg     <= ONE;
                                out_valid_reg <= 1'b1;
                                in_ready_reg  <= 1'b1;
                                occupancy_reg <= 2'd1;
                            end
                        end
                        ONE: begin
                            if (accept && out_fire) begin
                                main_reg <= bus.in_data;
                            end else if (accept) begin
                                skid_reg      <= bus.in_data;
                                state_reg     <= TWO;
                                out_valid_reg <= 1'b1;
                                in_ready_reg  <= 1'b0;
                                occupancy_reg <= 2'd2;
                            end else if (out_fire) begin
                                state_reg     <= EMPTY;
                                out_valid_reg <= 1'b0;
                                in_ready_reg  <= 1'b1;
                                occupancy_reg <= 2'd0;
                            end
                        end
                        TWO: begin
                            // Skid entry is always the younger one; promote it.
                            if (out_fire) begin
                                main_reg      <= skid_reg;
                                state_reg     <= ONE;
                                out_valid_reg <= 1'b1;
                                in_ready_reg  <= 1'b1;
                                occupancy_reg <= 2'd1;
                            end
                        end
                        default: begin
                            state_reg     <= EMPTY;
                            out_valid_reg <= 1'b0;
                            in_ready_reg  <= 1'b1;
                            occupancy_reg <= 2'd0;
                        end
                    endcase
                end
            end

            assign bus.in_ready  = in_ready_reg;
            assign bus.out_valid = out_valid_reg;
            assign bus.out_data  = main_reg;
            assign bus.occupancy = occupancy_reg;
        end else begin : g_single
            logic [DATA_W-1:0] main_reg;
            logic              out_valid_reg;

            logic in_ready;
            logic in_fire;
            logic accept;
            logic out_fire;

            assign in_ready = ~out_valid_reg | bus.out_ready;
            assign in_fire  = bus.in_valid & in_ready;
            assign accept   = in_fire & ~bus.in_kill & ~bus.flush;
            assign out_fire = out_valid_reg & bus.out_ready;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    main_reg      <= RST_DATA;
                    out_valid_reg <= 1'b0;
                end else if (bus.flush) begin
                    out_valid_reg <= 1'b0;
                end else if (accept) begin
                    main_reg      <= bus.in_data;
                    out_valid_reg <= 1'b1;
                end else if (out_fire) begin
                    out_valid_reg <= 1'b0;
                end
            end

            assign bus.in_ready  = in_ready;
            assign bus.out_valid = out_valid_reg;
            assign bus.out_data  = main_reg;
            assign bus.occupancy = {1'b0, out_valid_reg};
        end
    endgenerate

endmodule

// File: tb/tb_ysyx_041461_pipe_stage_reg.sv
// Scoreboard bench: drivers push expected beats, negedge monitors pop and
// compare whenever a DUT output beat fires.
module tb_ysyx_041461_pipe_stage_reg;

    localparam logic [99:0] RST_VAL = {4'h0, 32'h0, 64'h0000_0000_3000_0000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_041461_pipe_stage_reg_if #(.DATA_W(100)) b1 ();
    ysyx_041461_pipe_stage_reg_if #(.DATA_W(100)) b0 ();

    ysyx_041461_pipe_stage_reg #(.DATA_W(100), .RST_DATA(RST_VAL), .SKID(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    ysyx_041461_pipe_stage_reg #(.DATA_W(100), .RST_DATA(RST_VAL), .SKID(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [99:0] q1[$];
    logic [99:0] q0[$];
    logic [99:0] e1;
    logic [99:0] e0;
    bit en0 = 1'b0;

    task automatic chk(input string name, input logic [99:0] act, input logic [99:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard monitor for the skid variant
    always @(negedge clk) begin
        if (!rst && b1.out_valid && b1.out_ready) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out1_unexpected actual=%h required=no_beat", b1.out_data);
            end else begin
                e1 = q1.pop_front();
                chk("out1_data", b1.out_data, e1);
            end
        end
    end

    // Scoreboard monitor for the single-entry variant
    always @(negedge clk) begin
        if (!rst && b0.out_valid && b0.out_ready) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out0_unexpected actual=%h required=no_beat", b0.out_data);
            end else begin
                e0 = q0.pop_front();
                chk("out0_data", b0.out_data, e0);
            end
        end
        if (!rst && en0)
            chk("out0_in_ready_rel", b0.in_ready, !b0.out_valid || b0.out_ready);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a beat on the skid DUT until it is taken (bounded)
    task automatic send(input logic [99:0] d, input bit expect_out);
        bit done;
        done = 1'b0;
        b1.in_valid = 1'b1;
        b1.in_data  = d;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (b1.in_ready) begin
                done = 1'b1;
                if (expect_out) q1.push_back(d);
            end
            cyc();
        end
        b1.in_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=no_in_ready required=in_ready data=%h", d);
        end
    endtask

    initial begin
        int idx;
        b1.flush = 0; b1.in_valid = 0; b1.in_kill = 0; b1.in_data = '0; b1.out_ready = 0;
        b0.flush = 0; b0.in_valid = 0; b0.in_kill = 0; b0.in_data = '0; b0.out_ready = 0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", b1.out_valid, 0);
        chk("rst_occupancy", b1.occupancy, 0);
        chk("rst_out_data", b1.out_data, RST_VAL);
        chk("rst_in_ready", b1.in_ready, 1);
        chk("rst0_out_data", b0.out_data, RST_VAL);
        cyc();
        rst = 1'b0;

        // Streaming at full rate
        b1.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            b1.in_valid = 1'b1;
            b1.in_data  = 100'(i);
            @(negedge clk);
            chk("stream_in_ready", b1.in_ready, 1);
            if (i > 1) chk("stream_out_valid", b1.out_valid, 1);
            q1.push_back(100'(i));
            cyc();
        end
        b1.in_valid = 1'b0;
        repeat (3) cyc();
        chk("stream_drain", q1.size(), 0);

        // Backpressure: A, B fill the stage, C must wait
        b1.out_ready = 1'b0;
        send(100'hA, 1'b1);
        send(100'hB, 1'b1);
        b1.in_valid = 1'b1;
        b1.in_data  = 100'hC;
        @(negedge clk);
        chk("bp_in_ready", b1.in_ready, 0);
        chk("bp_occupancy", b1.occupancy, 2);
        chk("bp_out_valid", b1.out_valid, 1);
        chk("bp_out_data", b1.out_data, 100'hA);
        for (int k = 0; k < 2; k++) begin
            cyc();
            @(negedge clk);
            chk("bp_stable_data", b1.out_data, 100'hA);
            chk("bp_stable_ready", b1.in_ready, 0);
        end
        cyc();
        b1.out_ready = 1'b1;
        send(100'hC, 1'b1);
        repeat (3) cyc();
        chk("bp_drain", q1.size(), 0);
        chk("bp_empty_occ", b1.occupancy, 0);

        // Flush collides with a new beat; neither X nor Y reaches the output
        b1.out_ready = 1'b0;
        send(100'h1111, 1'b0);
        b1.in_valid = 1'b1;
        b1.in_data  = 100'h2222;
        b1.flush    = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", b1.in_ready, 1);
        cyc();
        b1.flush    = 1'b0;
        b1.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", b1.out_valid, 0);
        chk("flush_occupancy", b1.occupancy, 0);
        chk("flush_keeps_data", b1.out_data, 100'h1111);
        cyc();
        b1.out_ready = 1'b1;
        repeat (3) cyc();

        // Kill: handshake completes, nothing is stored
        b1.in_valid = 1'b1;
        b1.in_kill  = 1'b1;
        b1.in_data  = 100'h3333;
        @(negedge clk);
        chk("kill_in_ready", b1.in_ready, 1);
        cyc();
        b1.in_valid = 1'b0;
        b1.in_kill  = 1'b0;
        @(negedge clk);
        chk("kill_out_valid", b1.out_valid, 0);
        chk("kill_occupancy", b1.occupancy, 0);
        cyc();

        // Asynchronous reset mid-cycle while holding two entries
        b1.out_ready = 1'b0;
        send(100'h4444, 1'b0);
        send(100'h5555, 1'b0);
        @(negedge clk);
        chk("pre_rst_occupancy", b1.occupancy, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", b1.out_valid, 0);
        chk("arst_occupancy", b1.occupancy, 0);
        chk("arst_out_data", b1.out_data, RST_VAL);
        chk("arst_in_ready", b1.in_ready, 1);
        cyc();
        rst = 1'b0;

        // Single-entry variant with toggling backpressure
        en0 = 1'b1;
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            b0.out_ready = (c % 3 != 1);
            b0.in_valid  = (idx < 6);
            b0.in_data   = 100'(200 + idx);
            @(negedge clk);
            if (b0.in_valid && b0.in_ready) begin
                q0.push_back(100'(200 + idx));
                idx++;
            end
            cyc();
        end
        b0.in_valid  = 1'b0;
        b0.out_ready = 1'b1;
        repeat (2) cyc();
        en0 = 1'b0;
        chk("skid0_all_sent", idx, 6);
        chk("skid0_drain", q0.size(), 0);
        chk("skid0_out_valid", b0.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
